// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin arbiter sharing one memory command/data port between two cache requesters.
module cache_mem_arbiter #(
  parameter int BW_ADDR  = 26,
  parameter int BW_BLOCK = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               p0_req_i,
  input  logic               p0_req_block_i,
  input  logic               p0_rw_i,
  input  logic [BW_ADDR-1:0] p0_addr_i,
  output logic               p0_ready_o,
  input  logic [31:0]        p0_wdata_i,
  output logic               p0_wack_o,
  output logic [31:0]        p0_rdata_o,
  output logic               p0_rvalid_o,
  input  logic               p1_req_i,
  input  logic               p1_req_block_i,
  input  logic               p1_rw_i,
  input  logic [BW_ADDR-1:0] p1_addr_i,
  output logic               p1_ready_o,
  input  logic [31:0]        p1_wdata_i,
  output logic               p1_wack_o,
  output logic [31:0]        p1_rdata_o,
  output logic               p1_rvalid_o,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               mem_req_block_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  input  logic               mem_wack_i,
  input  logic [31:0]        mem_rdata_i,
  input  logic               mem_rvalid_i,
  output logic               owner_o,
  output logic               err_o
);
  typedef enum logic [1:0] {IDLE, RD_XFER, WR_XFER} state_t;
  state_t             state_q;
  logic [1:0]         pv_q, pb_q, prw_q;
  logic [BW_ADDR-1:0] pa_q [2];
  logic [BW_ADDR-1:0] addr_in [2];
  logic [BW_BLOCK:0]  cnt_q, cnt_d, tgt;
  logic               last_q, owner_q, mem_req_q, mem_blk_q, mem_rw_q, err_q;
  logic [BW_ADDR-1:0] mem_addr_q;
  logic [1:0]         req, blk_in, rw_in, rv, wk;
  logic               gnt, beat, stray;
  assign req        = {p1_req_i, p0_req_i};
  assign blk_in     = {p1_req_block_i, p0_req_block_i};
  assign rw_in      = {p1_rw_i, p0_rw_i};
  assign addr_in[0] = p0_addr_i;
  assign addr_in[1] = p1_addr_i;
  assign {p1_ready_o, p0_ready_o} = ~pv_q;
  assign rv = (state_q == RD_XFER && mem_rvalid_i) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign wk = (state_q == WR_XFER && mem_wack_i) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign {p1_rvalid_o, p0_rvalid_o} = rv;
  assign {p1_wack_o, p0_wack_o}     = wk;
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;
  assign mem_wdata_o = owner_q ? p1_wdata_i : p0_wdata_i;
  // With both pending the requester not granted last wins; otherwise whichever is pending.
  assign gnt   = &pv_q ? ~last_q : pv_q[1];
  assign beat  = |{rv, wk};
  assign stray = (mem_rvalid_i && state_q != RD_XFER) || (mem_wack_i && state_q != WR_XFER);
  assign cnt_d = cnt_q + 1'b1;
  assign tgt   = mem_blk_q ? ((BW_BLOCK+1)'(1) << BW_BLOCK) : (BW_BLOCK+1)'(1);
  assign mem_req_o       = mem_req_q;
  assign mem_req_block_o = mem_blk_q;
  assign mem_rw_o        = mem_rw_q;
  assign mem_addr_o      = mem_addr_q;
  assign owner_o         = owner_q;
  assign err_o           = err_q;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pv_q       <= '0;
      pb_q       <= '0;
      prw_q      <= '0;
      pa_q       <= '{default: '0};
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_blk_q  <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      err_q     <= err_q | stray | (|(req & pv_q));
      for (int n = 0; n < 2; n++)
        if (req[n] && !pv_q[n]) begin
          pv_q[n]  <= 1'b1;
          pb_q[n]  <= blk_in[n];
          prw_q[n] <= rw_in[n];
          pa_q[n]  <= addr_in[n];
        end
      case (state_q)
        IDLE: if (mem_ready_i && |pv_q) begin
          pv_q[gnt]  <= 1'b0;
          mem_req_q  <= 1'b1;
          mem_blk_q  <= pb_q[gnt];
          mem_rw_q   <= prw_q[gnt];
          mem_addr_q <= pa_q[gnt];
          owner_q    <= gnt;
          last_q     <= gnt;
          state_q    <= prw_q[gnt] ? WR_XFER : RD_XFER;
        end
        RD_XFER, WR_XFER: if (beat) begin
          cnt_q <= (cnt_d == tgt) ? '0 : cnt_d;
          if (cnt_d == tgt) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized scoreboard bench; a transaction-level model predicts commands, beats and status.
module tb_cache_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_i = 1'b1;
  logic        p0_req_i = 0, p0_req_block_i = 0, p0_rw_i = 0, p1_req_i = 0, p1_req_block_i = 0, p1_rw_i = 0;
  logic [25:0] p0_addr_i = '0, p1_addr_i = '0;
  logic [31:0] p0_wdata_i = '0, p1_wdata_i = '0, mem_rdata_i = '0;
  logic        mem_ready_i = 0, mem_wack_i = 0, mem_rvalid_i = 0;
  logic        p0_ready_o, p0_wack_o, p0_rvalid_o, p1_ready_o, p1_wack_o, p1_rvalid_o;
  logic [31:0] p0_rdata_o, p1_rdata_o, mem_wdata_o;
  logic        mem_req_o, mem_req_block_o, mem_rw_o, owner_o, err_o;
  logic [25:0] mem_addr_o;

  cache_mem_arbiter dut (
    .clock_i(clk), .reset_i(reset_i),
    .p0_req_i(p0_req_i), .p0_req_block_i(p0_req_block_i), .p0_rw_i(p0_rw_i), .p0_addr_i(p0_addr_i),
    .p0_ready_o(p0_ready_o), .p0_wdata_i(p0_wdata_i), .p0_wack_o(p0_wack_o), .p0_rdata_o(p0_rdata_o),
    .p0_rvalid_o(p0_rvalid_o),
    .p1_req_i(p1_req_i), .p1_req_block_i(p1_req_block_i), .p1_rw_i(p1_rw_i), .p1_addr_i(p1_addr_i),
    .p1_ready_o(p1_ready_o), .p1_wdata_i(p1_wdata_i), .p1_wack_o(p1_wack_o), .p1_rdata_o(p1_rdata_o),
    .p1_rvalid_o(p1_rvalid_o),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_req_block_o(mem_req_block_o), .mem_rw_o(mem_rw_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wack_i(mem_wack_i), .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i), .owner_o(owner_o), .err_o(err_o)
  );

  typedef struct packed {logic v, b, rw; logic [25:0] a;} cmd_t;
  typedef struct {int due; logic o, b, rw; logic [25:0] a;} exp_cmd_t;
  typedef struct {logic [1:0] rv, wk; logic [31:0] rd, wd;} beat_t;
  typedef struct {logic [1:0] rdy; logic e, o;} st_t;
  cmd_t     pend [2];
  exp_cmd_t cq [$];
  beat_t    bq [$];
  st_t      sq [$];
  bit       act, xrw, own_m, last_m = 1'b1, err_m;
  int       left, cyc, checks, errors;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Predicts this cycle's outputs from the current abstract state, then advances to the next edge.
  task automatic model();
    logic [1:0] req, old;
    beat_t bt;
    int g;
    req = {p1_req_i, p0_req_i};
    if (reset_i) begin
      pend[0].v = 0; pend[1].v = 0; act = 0; last_m = 1; own_m = 0; err_m = 0;
      cq.delete();
    end
    sq.push_back('{rdy: ~{pend[1].v, pend[0].v}, e: err_m, o: own_m});
    bt = '{rv: 2'b00, wk: 2'b00, rd: '0, wd: '0};
    if (act && !xrw && mem_rvalid_i) begin bt.rv[own_m] = 1'b1; bt.rd = mem_rdata_i; end
    if (act && xrw && mem_wack_i) begin bt.wk[own_m] = 1'b1; bt.wd = own_m ? p1_wdata_i : p0_wdata_i; end
    if (|{bt.rv, bt.wk}) bq.push_back(bt);
    if (reset_i) return;
    err_m |= (mem_rvalid_i && !(act && !xrw)) || (mem_wack_i && !(act && xrw)) || |(req & {pend[1].v, pend[0].v});
    old = {pend[1].v, pend[0].v};
    if (act) begin
      if (|{bt.rv, bt.wk}) begin left--; if (left == 0) act = 0; end
    end else if (mem_ready_i && old != 2'b00) begin
      g = (old == 2'b11) ? int'(!last_m) : int'(old[1]);
      cq.push_back('{due: cyc + 1, o: g[0], b: pend[g].b, rw: pend[g].rw, a: pend[g].a});
      act = 1; own_m = g[0]; last_m = g[0]; xrw = pend[g].rw; left = pend[g].b ? 4 : 1; pend[g].v = 0;
    end
    if (req[0] && !old[0]) pend[0] = {1'b1, p0_req_block_i, p0_rw_i, p0_addr_i};
    if (req[1] && !old[1]) pend[1] = {1'b1, p1_req_block_i, p1_rw_i, p1_addr_i};
  endtask

  task automatic drive(input bit rs, input bit q0, input bit q1, input bit mr, input bit rv, input bit wk);
    cyc++;
    reset_i = rs; p0_req_i = q0; p1_req_i = q1; mem_ready_i = mr; mem_rvalid_i = rv; mem_wack_i = wk;
    mem_rdata_i = $urandom; p0_wdata_i = $urandom; p1_wdata_i = $urandom;
    model();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int n, input bit b, input bit rw, input logic [25:0] a);
    if (n == 0) begin p0_req_block_i = b; p0_rw_i = rw; p0_addr_i = a; end
    else begin p1_req_block_i = b; p1_rw_i = rw; p1_addr_i = a; end
  endtask

  task automatic serve(input int n);
    repeat (n) drive(0, 0, 0, 1, act && !xrw && $urandom_range(3) != 0, act && xrw && $urandom_range(3) != 0);
  endtask

  initial begin
    bit q0, q1, rv, wk;
    @(negedge clk);
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    set_cmd(0, 1, 0, 26'h100);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) begin
      set_cmd(0, 0, 0, 26'h040); set_cmd(1, 0, 0, 26'h1C0);
      drive(0, 1, 1, 1, 0, 0);
      serve(12);
    end
    set_cmd(1, 1, 1, 26'h2C0);
    drive(0, 0, 1, 1, 0, 0);
    serve(14);
    set_cmd(0, 1, 0, 26'h3A4);
    drive(0, 1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    set_cmd(0, 0, 1, 26'h155);
    drive(0, 1, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    serve(12);
    drive(1, 0, 0, 0, 0, 0);
    set_cmd(0, 0, 0, 26'h0A8);
    drive(0, 1, 0, 1, 0, 0);
    serve(6);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    set_cmd(0, 1, 0, 26'h080);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 1, 0);
    repeat (2) drive(0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2000) begin
      q0 = $urandom_range(3) == 0 && (!pend[0].v || $urandom_range(15) == 0);
      q1 = $urandom_range(3) == 0 && (!pend[1].v || $urandom_range(15) == 0);
      set_cmd(0, 1'($urandom), 1'($urandom), 26'($urandom));
      set_cmd(1, 1'($urandom), 1'($urandom), 26'($urandom));
      rv = (act && !xrw) ? $urandom_range(9) < 6 : $urandom_range(49) == 0;
      wk = (act && xrw) ? $urandom_range(9) < 6 : $urandom_range(49) == 0;
      drive($urandom_range(299) == 0, q0, q1, $urandom_range(3) != 0, rv, wk);
    end
    serve(40);
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    chk("cmd_queue_left", 64'(cq.size()), 64'd0);
    chk("beat_queue_left", 64'(bq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    st_t st;
    exp_cmd_t c;
    beat_t b;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() != 0) begin
        st = sq.pop_front();
        chk("ready", 64'({p1_ready_o, p0_ready_o}), 64'(st.rdy));
        chk("err", 64'(err_o), 64'(st.e));
        chk("owner", 64'(owner_o), 64'(st.o));
      end
      if (mem_req_o) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req: got unexpected command addr %0h expected none (cycle %0d)", mem_addr_o, cyc);
        end else begin
          c = cq.pop_front();
          chk("req_cycle", 64'(cyc), 64'(c.due));
          chk("req_addr", 64'(mem_addr_o), 64'(c.a));
          chk("req_block", 64'(mem_req_block_o), 64'(c.b));
          chk("req_rw", 64'(mem_rw_o), 64'(c.rw));
          chk("req_owner", 64'(owner_o), 64'(c.o));
        end
      end
      if (|{p1_rvalid_o, p0_rvalid_o, p1_wack_o, p0_wack_o}) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat: got rvalid %b wack %b expected none (cycle %0d)", {p1_rvalid_o, p0_rvalid_o}, {p1_wack_o, p0_wack_o}, cyc);
        end else begin
          b = bq.pop_front();
          chk("rvalid", 64'({p1_rvalid_o, p0_rvalid_o}), 64'(b.rv));
          chk("wack", 64'({p1_wack_o, p0_wack_o}), 64'(b.wk));
          if (|b.rv) chk("rdata", {p1_rdata_o, p0_rdata_o}, {b.rd, b.rd});
          if (|b.wk) chk("mem_wdata", 64'(mem_wdata_o), 64'(b.wd));
        end
      end
    end
  end
endmodule
